id_exe_elastic_stage: RTL and testbench

//  Parametrised ID->EXE pipeline stage register with a valid/ready handshake, an optional skid buffer and a

---
 rtl/id_exe_elastic_stage.sv | 105 ++++++++++
 tb/tb_id_exe_elastic_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_elastic_stage.sv
// ID->EXE stage register with valid/ready handshake, optional 2-entry skid and synchronous flush.
// An empty stage presents CTRL_NOP so that EXE never sees an enabled control on a bubble.
module id_exe_elastic_stage #(
    parameter int                 DATA_W   = 192,
    parameter int                 CTRL_W   = 9,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter bit                 SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, emit;
    logic              load_main, load_skid, move_skid;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    // Next-state logic; flush wins over any handshake in the same cycle
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (accept) state_nxt = S_BUSY;
                S_BUSY: begin
                    if (accept && !emit)      state_nxt = SKID ? S_FULL : S_BUSY;
                    else if (!accept && emit) state_nxt = S_EMPTY;
                end
                S_FULL:  if (emit) state_nxt = S_BUSY;
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    // Outputs; with SKID the ready only decodes the state flop, never out_ready
    always_comb begin
        out_valid = (state != S_EMPTY);
        occ       = state;
        if (SKID) in_ready = (state != S_FULL) & ~flush;
        else      in_ready = ((state == S_EMPTY) | out_ready) & ~flush;
    end

    assign load_main = accept & ((state == S_EMPTY) | ((state == S_BUSY) & emit));
    assign load_skid = accept & (state == S_BUSY) & ~emit;
    assign move_skid = (state == S_FULL) & emit;

    // Payload registers; main_data keeps its last value when the stage drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            main_ctrl <= CTRL_NOP;
            skid_data <= '0;
            skid_ctrl <= CTRL_NOP;
        end else if (flush) begin
            main_data <= '0;
            main_ctrl <= CTRL_NOP;
            skid_data <= '0;
            skid_ctrl <= CTRL_NOP;
        end else begin
            if (load_main) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (move_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    assign out_data = main_data;
    assign out_ctrl = out_valid ? main_ctrl : CTRL_NOP;

endmodule

// File: tb/tb_id_exe_elastic_stage.sv
// Bench for id_exe_elastic_stage: a SKID=1 and a SKID=0 instance share stimulus and are
// compared against a FIFO-queue reference, plus a vector table and hand-built corner sequences.
module tb_id_exe_elastic_stage;

    localparam int DW = 192;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          ir1, ov1, ir0, ov0;
    logic [DW-1:0] od1, od0;
    logic [CW-1:0] oc1, oc0;
    logic [1:0]    occ1, occ0;

    always #5 clk = ~clk;

    id_exe_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP('0), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ctrl(oc1), .occ(occ1));

    id_exe_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP('0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_ctrl(oc0), .occ(occ0));

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    typedef struct {
        bit         iv;
        logic [7:0] tag;
        bit         ordy;
        bit         fl;
        bit         ir;     // in_ready before the edge
        bit         ov;     // state after the edge
        int         occ;
        logic [7:0] etag;
    } vec_t;

    beat_t         q1[$], q0[$];
    logic [DW-1:0] last1, last0;
    int            errs = 0, checks = 0;
    vec_t          tbl[14];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit iv, logic [7:0] tag, bit ordy, bit fl, bit ir, bit ov, int occ,
                                logic [7:0] etag);
        vec_t v;
        v.iv = iv; v.tag = tag; v.ordy = ordy; v.fl = fl;
        v.ir = ir; v.ov = ov; v.occ = occ; v.etag = etag;
        return v;
    endfunction

    function automatic logic [DW-1:0] tdata(logic [7:0] t);
        return {24{t}};
    endfunction

    function automatic logic [CW-1:0] tctrl(logic [7:0] t);
        return {1'b1, t};
    endfunction

    task automatic model_reset();
        q1.delete(); q0.delete();
        last1 = '0; last0 = '0;
    endtask

    // Queue view: head of the queue is what EXE must see; empty means NOP control, last data
    task automatic model_check();
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        ed = (q1.size() > 0) ? q1[0].d : last1;
        ec = (q1.size() > 0) ? q1[0].c : '0;
        chk("s1.out_valid", ov1, q1.size() > 0);
        chk("s1.occ", occ1, q1.size());
        chk("s1.out_data", od1, ed);
        chk("s1.out_ctrl", oc1, ec);
        chk("s1.in_ready", ir1, (q1.size() < 2) && !flush);
        ed = (q0.size() > 0) ? q0[0].d : last0;
        ec = (q0.size() > 0) ? q0[0].c : '0;
        chk("s0.out_valid", ov0, q0.size() > 0);
        chk("s0.occ", occ0, q0.size());
        chk("s0.out_data", od0, ed);
        chk("s0.out_ctrl", oc0, ec);
        chk("s0.in_ready", ir0, ((q0.size() == 0) || out_ready) && !flush);
    endtask

    task automatic drive(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit ordy, input bit fl);
        in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
        #1;
        model_check();
    endtask

    // Clock edge: update the queues from the handshake rules, then land on the next negedge
    task automatic advance();
        beat_t b;
        bit acc1, acc0, em1, em0;
        b.d = in_data; b.c = in_ctrl;
        acc1 = in_valid && (q1.size() < 2) && !flush;
        acc0 = in_valid && ((q0.size() == 0) || out_ready) && !flush;
        em1  = (q1.size() > 0) && out_ready;
        em0  = (q0.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            q1.delete(); last1 = '0;
            q0.delete(); last0 = '0;
        end else begin
            if (em1) last1 = q1.pop_front().d;
            if (acc1) q1.push_back(b);
            if (em0) last0 = q0.pop_front().d;
            if (acc0) q0.push_back(b);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        model_reset();

        tbl[0]  = mk(1, 8'h11, 0, 0, 1, 1, 1, 8'h11);
        tbl[1]  = mk(1, 8'h22, 0, 0, 1, 1, 2, 8'h11);
        tbl[2]  = mk(1, 8'h33, 0, 0, 0, 1, 2, 8'h11);
        tbl[3]  = mk(0, 8'h00, 0, 0, 0, 1, 2, 8'h11);
        tbl[4]  = mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h22);
        tbl[5]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 8'h22);
        tbl[6]  = mk(1, 8'h44, 0, 0, 1, 1, 1, 8'h44);
        tbl[7]  = mk(1, 8'h55, 0, 0, 1, 1, 2, 8'h44);
        tbl[8]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tbl[9]  = mk(1, 8'h66, 1, 1, 0, 0, 0, 8'h00);
        tbl[10] = mk(0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
        tbl[11] = mk(1, 8'h77, 1, 0, 1, 1, 1, 8'h77);
        tbl[12] = mk(1, 8'h88, 1, 0, 1, 1, 1, 8'h88);
        tbl[13] = mk(0, 8'h00, 1, 0, 1, 0, 0, 8'h88);

        @(negedge clk);
        #1;
        chk("rst.out_valid", ov1, 1'b0);
        chk("rst.occ", occ1, 2'd0);
        chk("rst.out_data", od1, '0);
        chk("rst.out_ctrl", oc1, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.in_ready_after", ir1, 1'b1);

        // Vector table on the skid instance
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].iv, tdata(tbl[i].tag), tctrl(tbl[i].tag), tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d.in_ready", i), ir1, tbl[i].ir);
            advance();
            chk($sformatf("tbl%0d.out_valid", i), ov1, tbl[i].ov);
            chk($sformatf("tbl%0d.occ", i), occ1, tbl[i].occ);
            chk($sformatf("tbl%0d.out_data", i), od1, tdata(tbl[i].etag));
            chk($sformatf("tbl%0d.out_ctrl", i), oc1, tbl[i].ov ? tctrl(tbl[i].etag) : '0);
        end

        // Streaming: 8 beats back to back, 1-cycle latency, ready never drops
        for (int i = 0; i < 8; i++) begin
            drive(1, tdata(8'hA0 + 8'(i)), tctrl(8'hA0 + 8'(i)), 1, 0);
            chk("stream.in_ready", ir1, 1'b1);
            advance();
            chk("stream.out_data", od1, tdata(8'hA0 + 8'(i)));
        end
        drive(0, '0, '0, 1, 0);
        advance();

        // No-skid stage: stall drops in_ready combinationally, release swaps in one cycle
        drive(1, tdata(8'hB1), tctrl(8'hB1), 0, 0);
        advance();
        drive(1, tdata(8'hB2), tctrl(8'hB2), 0, 0);
        chk("s0.stall_in_ready", ir0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("s0.release_in_ready", ir0, 1'b1);
        model_check();
        advance();
        chk("s0.swap_data", od0, tdata(8'hB2));
        chk("s0.swap_valid", ov0, 1'b1);
        drive(0, '0, '0, 1, 0);
        advance();

        // Randomized traffic against the queue reference
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0,
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  CW'($urandom_range(511)),
                  ($urandom % 3) != 0,
                  ($urandom % 16) == 0);
            advance();
        end

        // Async reset in the middle of a cycle while FULL
        drive(0, '0, '0, 0, 1);
        advance();
        drive(1, tdata(8'hC1), tctrl(8'hC1), 0, 0);
        advance();
        drive(1, tdata(8'hC2), tctrl(8'hC2), 0, 0);
        advance();
        chk("pre_rst.occ", occ1, 2'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.out_valid", ov1, 1'b0);
        chk("async_rst.occ", occ1, 2'd0);
        chk("async_rst.out_data", od1, '0);
        chk("async_rst.out_ctrl", oc1, '0);
        chk("async_rst.s0_out_valid", ov0, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 0);
            advance();
        end
        drive(0, '0, '0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
